// File: rtl/tft_busmod.sv
// tft_busmod
// ----------
// Turns calls from the TFT control layer into 8080-style parallel write
// cycles on the panel bus. A call is one of three kinds:
//   iCall[2] register write : command phase (iAddr) then data phase (iData)
//   iCall[1] command only   : command phase (iAddr)
//   iCall[0] data only      : data phase (iData)
// If more than one bit is set, the highest bit wins.
//
// Each phase is SETUP (T_SETUP cycles, WR_N high) -> WRL (T_WRL cycles,
// WR_N low) -> WRH (T_WRH cycles, WR_N high, bus held). After the last phase
// the FSM goes DONE (oDone pulse, CS_N released) -> DONE_CLR -> IDLE.
//
// Ports
//   CLOCK     in   1   system clock, rising edge
//   RESET     in   1   asynchronous reset, active low
//   iCall     in   3   call request bits (see above)
//   oDone     out  1   one-cycle completion pulse
//   iAddr     in   8   command / register index
//   iData     in   16  register value or pixel colour
//   TFT_CS_N  out  1   panel chip select, active low
//   TFT_RS    out  1   0 = command, 1 = data
//   TFT_WR_N  out  1   write strobe, panel latches on rising edge
//   TFT_RD_N  out  1   read strobe, tied high (write-only bus)
//   TFT_DB    out  16  panel data bus
//   oErr      out  1   only with TFT_BUS_ERR_EN: sticky protocol error flag
//
// Configuration
//   TFT_BUS_ERR_EN  when defined, adds oErr. It is set when iCall is
//                   multi-hot as it is sampled in IDLE, or when iCall falls
//                   to zero while a transaction is on the bus. Only RESET
//                   clears it.

module tft_busmod #(
    parameter int T_SETUP = 1,
    parameter int T_WRL   = 2,
    parameter int T_WRH   = 2
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [2:0]  iCall,
    output logic        oDone,
    input  logic [7:0]  iAddr,
    input  logic [15:0] iData,
    output logic        TFT_CS_N,
    output logic        TFT_RS,
    output logic        TFT_WR_N,
    output logic        TFT_RD_N,
    output logic [15:0] TFT_DB
`ifdef TFT_BUS_ERR_EN
    ,
    output logic        oErr
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WRL,
        WRH,
        DONE,
        DONE_CLR
    } state_t;

    localparam logic [3:0] SETUP_LOAD = 4'(T_SETUP - 1);
    localparam logic [3:0] WRL_LOAD   = 4'(T_WRL - 1);
    localparam logic [3:0] WRH_LOAD   = 4'(T_WRH - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        rs_q, rs_d;
    logic [15:0] db_q, db_d;
    logic [15:0] data_q, data_d;
    logic        second_q, second_d;

`ifdef TFT_BUS_ERR_EN
    logic        err_q, err_d;
`endif

    // State register plus the latched bus values. The command index goes
    // straight into db_q at sampling time, so only the data word needs its
    // own holding register for the second phase of a register write.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            rs_q     <= 1'b1;
            db_q     <= 16'h0000;
            data_q   <= 16'h0000;
            second_q <= 1'b0;
`ifdef TFT_BUS_ERR_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rs_q     <= rs_d;
            db_q     <= db_d;
            data_q   <= data_d;
            second_q <= second_d;
`ifdef TFT_BUS_ERR_EN
            err_q    <= err_d;
`endif
        end
    end

    // Next-state logic. The phase counter is loaded with (length-1) on
    // entry to each timed state and the state advances when it hits zero.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rs_d     = rs_q;
        db_d     = db_q;
        data_d   = data_q;
        second_d = second_q;
        unique case (state_q)
            IDLE: begin
                if (iCall != 3'b000) begin
                    state_d = SETUP;
                    cnt_d   = SETUP_LOAD;
                    data_d  = iData;
                    if (iCall[2] || iCall[1]) begin
                        rs_d     = 1'b0;
                        db_d     = {8'h00, iAddr};
                        second_d = iCall[2];
                    end else begin
                        rs_d     = 1'b1;
                        db_d     = iData;
                        second_d = 1'b0;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = WRL;
                    cnt_d   = WRL_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRL: begin
                if (cnt_q == 4'd0) begin
                    state_d = WRH;
                    cnt_d   = WRH_LOAD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRH: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (second_q) begin
                    // Register write: chain straight into the data phase
                    // without releasing chip select.
                    state_d  = SETUP;
                    cnt_d    = SETUP_LOAD;
                    rs_d     = 1'b1;
                    db_d     = data_q;
                    second_d = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:     state_d = DONE_CLR;
            DONE_CLR: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

`ifdef TFT_BUS_ERR_EN
    // Sticky error: multi-hot call at sampling, or the caller abandoning
    // its call while the bus cycle is still in progress.
    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && (iCall & (iCall - 3'd1)) != 3'b000) begin
            err_d = 1'b1;
        end
        if ((state_q == SETUP || state_q == WRL || state_q == WRH) && iCall == 3'b000) begin
            err_d = 1'b1;
        end
    end

    assign oErr = err_q;
`endif

    // Outputs decoded from the registered state, so an asynchronous reset
    // returns every pin to its idle level at once.
    always_comb begin
        TFT_CS_N = !(state_q == SETUP || state_q == WRL || state_q == WRH);
        TFT_WR_N = (state_q != WRL);
        TFT_RD_N = 1'b1;
        TFT_RS   = rs_q;
        TFT_DB   = db_q;
        oDone    = (state_q == DONE);
    end

endmodule
